// File: rtl/hqc_rsencod_top.sv
// Systematic Reed-Solomon encoder over GF(2^8) for HQC: the message is loaded in parallel, parity
// is built by a byte-serial LFSR, and the codeword is streamed out parity-first over valid/ready.
module hqc_rsencod_top #(
    parameter int PARAM_SECURITY = 128,
    parameter int PARAM_K     = (PARAM_SECURITY == 128) ? 16 : (PARAM_SECURITY == 192) ? 24 : 32,
    parameter int PARAM_N1    = (PARAM_SECURITY == 128) ? 46 : (PARAM_SECURITY == 192) ? 56 : 90,
    parameter int PARAM_DELTA = (PARAM_SECURITY == 128) ? 15 : (PARAM_SECURITY == 192) ? 16 : 29,
    parameter int PARAM_G     = 2 * PARAM_DELTA + 1,
    parameter int DIN_W       = 8 * PARAM_K
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [DIN_W-1:0] msg_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [7:0]       dout_o,
    output logic             dout_valid_o,
    output logic             dout_last_o,
    input  logic             dout_ready_i
);

    localparam int P  = 2 * PARAM_DELTA;
    localparam int CW = $clog2(PARAM_N1);
    localparam int KW = $clog2(PARAM_K);

    // GF(2^8) multiply modulo x^8+x^4+x^3+x^2+1; with one constant operand this folds to XOR trees.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
        end
        return acc;
    endfunction

    // Generator g(x) = (x - a^1)(x - a^2)...(x - a^(2*DELTA)), coefficient j in byte j; monic.
    function automatic logic [8*PARAM_G-1:0] gen_poly();
        logic [7:0]             c [PARAM_G];
        logic [7:0]             root;
        logic [8*PARAM_G-1:0]   res;
        for (int j = 0; j < PARAM_G; j++) c[j] = 8'h00;
        c[0] = 8'h01;
        root = 8'h01;
        for (int i = 1; i < PARAM_G; i++) begin
            root = gf_mul(root, 8'h02);
            for (int j = PARAM_G - 1; j > 0; j--) c[j] = c[j-1] ^ gf_mul(c[j], root);
            c[0] = gf_mul(c[0], root);
        end
        for (int j = 0; j < PARAM_G; j++) res[8*j +: 8] = c[j];
        return res;
    endfunction

    localparam logic [8*PARAM_G-1:0] GEN = gen_poly();

    typedef enum logic [1:0] {S_IDLE, S_ENC, S_OUT, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_msg [PARAM_K];
    logic [7:0]      r_par [P];
    logic [7:0]      w_fb;
    logic [KW-1:0]   w_msg_idx;
    logic [7:0]      w_cw [PARAM_N1];
    logic            w_enc_last;
    logic            w_out_last;
    logic            w_accept;

    assign w_enc_last = (r_cnt == CW'(PARAM_K - 1));
    assign w_out_last = (r_cnt == CW'(PARAM_N1 - 1));
    assign w_accept   = (r_state == S_OUT) && dout_ready_i;
    assign w_msg_idx  = KW'(PARAM_K - 1) - KW'(r_cnt);
    assign w_fb       = r_msg[w_msg_idx] ^ r_par[P-1];

    // Codeword view: parity in the low positions, message bytes above it.
    always_comb begin
        for (int n = 0; n < P; n++) w_cw[n] = r_par[n];
        for (int n = 0; n < PARAM_K; n++) w_cw[P+n] = r_msg[n];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_next = S_ENC;
            S_ENC:   if (w_enc_last) w_next = S_OUT;
            S_OUT:   if (w_accept && w_out_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            // NOTE: the message and parity arrays are reset too, so an aborted encode leaves no stale bytes.
            for (int i = 0; i < PARAM_K; i++) r_msg[i] <= 8'h00;
            for (int j = 0; j < P; j++) r_par[j] <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_cnt <= '0;
                    for (int i = 0; i < PARAM_K; i++) r_msg[i] <= msg_i[8*i +: 8];
                    for (int j = 0; j < P; j++) r_par[j] <= 8'h00;
                end
                S_ENC: begin
                    for (int j = P - 1; j > 0; j--) r_par[j] <= r_par[j-1] ^ gf_mul(w_fb, GEN[8*j +: 8]);
                    r_par[0] <= gf_mul(w_fb, GEN[7:0]);
                    r_cnt    <= w_enc_last ? '0 : r_cnt + CW'(1);
                end
                S_OUT: if (w_accept) r_cnt <= w_out_last ? '0 : r_cnt + CW'(1);
                default: r_cnt <= '0;
            endcase
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    always_comb begin
        busy_o       = (r_state == S_ENC) || (r_state == S_OUT);
        done_o       = (r_state == S_DONE);
        dout_valid_o = (r_state == S_OUT);
        dout_last_o  = (r_state == S_OUT) && w_out_last;
        dout_o       = (r_state == S_OUT) ? w_cw[r_cnt] : 8'h00;
    end

endmodule
